// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port scheduler: grants drawing sources one at a time in ascending ID
// order on every frame pulse, with a per-grant watchdog and frame-overrun detection.
module fb_write_scheduler #(
    parameter int NUM_SOURCES     = 2,
    parameter int SEL_W           = 1,
    parameter int WATCHDOG_CYCLES = 400000
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame,
    input  logic [NUM_SOURCES-1:0] src_enable,
    input  logic [NUM_SOURCES-1:0] src_done,
    output logic [NUM_SOURCES-1:0] src_start,
    output logic [SEL_W-1:0]       write_source_sel,
    output logic                   write_awaited,
    output logic                   pass_done,
    output logic                   frame_overrun,
    output logic                   src_timeout
);

    // Search index must be able to hold NUM_SOURCES ("past the last source").
    localparam int IDX_W = $clog2(NUM_SOURCES + 1);
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_START  = 3'd2,
        S_DRAW   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_search;
    logic [IDX_W-1:0]       r_cur;
    logic [WD_W-1:0]        r_wd;
    logic [SEL_W-1:0]       r_sel;
    logic [NUM_SOURCES-1:0] r_src_start;
    logic                   r_awaited;
    logic                   r_pass_done;
    logic                   r_overrun;
    logic                   r_timeout;

    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       w_search_nxt;
    logic [IDX_W-1:0]       w_cur_nxt;
    logic [WD_W-1:0]        w_wd_nxt;
    logic [WD_W-1:0]        w_wd_inc;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [NUM_SOURCES-1:0] w_start_nxt;
    logic                   w_overrun_nxt;
    logic                   w_timeout_nxt;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [SEL_W-1:0]       w_pick_sel;
    logic                   w_done_cur;

    assign w_wd_inc = (r_wd == {WD_W{1'b1}}) ? r_wd : r_wd + WD_W'(1);

    // Lowest enabled ID at or above the search index, and the granted source's done bit.
    always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        w_pick_sel = '0;
        w_done_cur = 1'b0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            w_found    = w_found | (src_enable[i] & (IDX_W'(i) >= r_search));
            w_pick_idx = (src_enable[i] && (IDX_W'(i) >= r_search)) ? IDX_W'(i) : w_pick_idx;
            w_pick_sel = (src_enable[i] && (IDX_W'(i) >= r_search)) ? SEL_W'(i) : w_pick_sel;
            w_done_cur = w_done_cur | (src_done[i] & (r_cur == IDX_W'(i)));
        end
    end

    // Next-state logic; every output is derived from the next state so it can be registered.
    always_comb begin
        w_state_nxt   = r_state;
        w_search_nxt  = r_search;
        w_cur_nxt     = r_cur;
        w_sel_nxt     = r_sel;
        w_wd_nxt      = r_wd;
        w_overrun_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame) begin
                    w_state_nxt  = S_SELECT;
                    w_search_nxt = '0;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_SELECT, S_START: begin
                if (frame) begin
                    w_overrun_nxt = 1'b1;
                    w_state_nxt   = S_SELECT;
                    w_search_nxt  = '0;
                end else if (r_state == S_START) begin
                    w_state_nxt = S_DRAW;
                    w_wd_nxt    = '0;
                end else if (w_found) begin
                    w_state_nxt = S_START;
                    w_cur_nxt   = w_pick_idx;
                    w_sel_nxt   = w_pick_sel;
                end else begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_DRAW: begin
                // A frame beats a same-cycle done: the grant is aborted, not completed.
                if (frame) begin
                    w_overrun_nxt = 1'b1;
                    w_state_nxt   = S_SELECT;
                    w_search_nxt  = '0;
                end else if (w_done_cur || (r_wd >= WD_LAST)) begin
                    w_state_nxt  = S_SELECT;
                    w_search_nxt = r_cur + IDX_W'(1);
                end else begin
                    w_wd_nxt = w_wd_inc;
                end
            end
            S_FINISH: begin
                if (frame) begin
                    w_state_nxt  = S_SELECT;
                    w_search_nxt = '0;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_search_nxt = '0;
            end
        endcase

        // The timeout pulse coincides with the last DRAW cycle the watchdog allows.
        w_timeout_nxt = (w_state_nxt == S_DRAW) && (w_wd_nxt == WD_LAST);
        w_start_nxt   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_start_nxt[i] = (w_state_nxt == S_START) && (w_cur_nxt == IDX_W'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_search    <= '0;
            r_cur       <= '0;
            r_wd        <= '0;
            r_sel       <= '0;
            r_src_start <= '0;
            r_awaited   <= 1'b0;
            r_pass_done <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_search    <= w_search_nxt;
            r_cur       <= w_cur_nxt;
            r_wd        <= w_wd_nxt;
            r_sel       <= w_sel_nxt;
            r_src_start <= w_start_nxt;
            r_awaited   <= (w_state_nxt == S_DRAW);
            r_pass_done <= (w_state_nxt == S_FINISH);
            r_overrun   <= w_overrun_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign src_start        = r_src_start;
    assign write_source_sel = r_sel;
    assign write_awaited    = r_awaited;
    assign pass_done        = r_pass_done;
    assign frame_overrun    = r_overrun;
    assign src_timeout      = r_timeout;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler: a timestamp-based reference model predicts pulses
// and per-cycle status; a negedge monitor compares whatever the DUT presents.
module tb_fb_write_scheduler;
    localparam int N  = 2;
    localparam int SW = 1;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          resetN;
    logic          frame;
    logic [N-1:0]  src_enable;
    logic [N-1:0]  src_done;
    logic [N-1:0]  src_start;
    logic [SW-1:0] write_source_sel;
    logic          write_awaited;
    logic          pass_done;
    logic          frame_overrun;
    logic          src_timeout;

    always #5 clk = ~clk;

    fb_write_scheduler #(.NUM_SOURCES(N), .SEL_W(SW), .WATCHDOG_CYCLES(W)) dut (
        .clk(clk), .resetN(resetN), .frame(frame), .src_enable(src_enable),
        .src_done(src_done), .src_start(src_start), .write_source_sel(write_source_sel),
        .write_awaited(write_awaited), .pass_done(pass_done),
        .frame_overrun(frame_overrun), .src_timeout(src_timeout)
    );

    // kind: 0 start, 1 pass_done, 2 overrun, 3 timeout
    typedef struct { int cyc; int kind; int id; } ev_t;
    typedef struct { int cyc; logic aw; int sel; } st_t;
    ev_t evq[$];
    st_t stq[$];
    int  start_log[$], start_id_log[$], pass_log[$], ovr_log[$], tmo_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [N-1:0] cur_en;

    // Reference model: timestamps of the upcoming events for the current pass.
    int m_sel_cyc, m_search, m_gnt, m_gnt_from, m_gnt_to, m_start_cyc, m_fin_cyc, m_ovr_cyc, m_last_sel;

    function automatic void model_reset();
        m_sel_cyc = -1; m_search = 0; m_gnt = -1; m_gnt_from = -1; m_gnt_to = -1;
        m_start_cyc = -1; m_fin_cyc = -1; m_ovr_cyc = -1; m_last_sel = 0;
    endfunction

    function automatic void model_step(int c, logic fr, logic [N-1:0] en, logic [N-1:0] dn);
        ev_t e;
        st_t s;
        bit  busy;
        int  pick;
        if (m_start_cyc == c) begin e.cyc = c; e.kind = 0; e.id = m_gnt; evq.push_back(e); end
        if (m_fin_cyc == c)   begin e.cyc = c; e.kind = 1; e.id = 0; evq.push_back(e); end
        if (m_ovr_cyc == c)   begin e.cyc = c; e.kind = 2; e.id = 0; evq.push_back(e); end
        if (m_gnt >= 0 && c == m_gnt_to) begin e.cyc = c; e.kind = 3; e.id = m_gnt; evq.push_back(e); end
        s.cyc = c;
        s.aw  = (m_gnt >= 0 && c >= m_gnt_from);
        s.sel = m_last_sel;
        stq.push_back(s);
        busy = (m_sel_cyc == c) || (m_gnt >= 0);
        if (fr) begin
            if (busy) m_ovr_cyc = c + 1;
            m_gnt = -1; m_start_cyc = -1; m_sel_cyc = c + 1; m_search = 0;
        end else if (m_sel_cyc == c) begin
            pick = -1;
            for (int i = N - 1; i >= m_search; i--) if (en[i]) pick = i;
            m_sel_cyc = -1;
            if (pick >= 0) begin
                m_gnt = pick; m_last_sel = pick; m_start_cyc = c + 1;
                m_gnt_from = c + 2; m_gnt_to = c + 1 + W;
            end else begin
                m_fin_cyc = c + 1;
            end
        end else if (m_gnt >= 0 && c >= m_gnt_from && (dn[m_gnt] || c == m_gnt_to)) begin
            m_sel_cyc = c + 1; m_search = m_gnt + 1; m_gnt = -1;
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic fr, logic [N-1:0] en, logic [N-1:0] dn);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        cyc++;
        frame = fr; src_enable = en; src_done = dn;
        model_step(cyc, fr, en, dn);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(1'b0, cur_en, '0);
    endtask

    task automatic clear_logs();
        start_log.delete(); start_id_log.delete(); pass_log.delete(); ovr_log.delete(); tmo_log.delete();
    endtask

    task automatic do_reset();
        #1;
        resetN = 1'b0;
        #1;
        chk("rst_async_start", int'(src_start), 0);
        chk("rst_async_sel", int'(write_source_sel), 0);
        chk("rst_async_flags", int'({write_awaited, pass_done, frame_overrun, src_timeout}), 0);
        evq.delete(); stq.delete(); model_reset(); clear_logs();
        frame = 1'b0; src_done = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_pulse(int kind, string name);
        ev_t e;
        checks++;
        if (evq.size() == 0 || evq[0].cyc != cyc || evq[0].kind != kind) begin
            errors++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d expected none", name, cyc);
        end else begin
            e = evq.pop_front();
            if (kind == 0 && src_start !== N'(1 << e.id)) begin
                errors++;
                $display("FAIL start_vector: got %b expected %b at cycle %0d", src_start, N'(1 << e.id), cyc);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents status or a pulse.
    always @(negedge clk) begin
        st_t s;
        if (resetN === 1'b1 && cyc > 0) begin
            checks++;
            if (stq.size() == 0) begin
                errors++;
                $display("FAIL status_queue: got empty expected entry at cycle %0d", cyc);
            end else begin
                s = stq.pop_front();
                if (s.cyc != cyc || write_awaited !== s.aw || write_source_sel !== SW'(s.sel)) begin
                    errors++;
                    $display("FAIL status: got aw=%b sel=%0d expected aw=%b sel=%0d at cycle %0d",
                             write_awaited, write_source_sel, s.aw, s.sel, cyc);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_pulse: got none expected kind %0d at cycle %0d", evq[0].kind, evq[0].cyc);
                void'(evq.pop_front());
            end
            if (src_start != '0) begin
                check_pulse(0, "src_start");
                start_log.push_back(cyc);
                start_id_log.push_back(int'(write_source_sel));
            end
            if (pass_done)     begin check_pulse(1, "pass_done");     pass_log.push_back(cyc); end
            if (frame_overrun) begin check_pulse(2, "frame_overrun"); ovr_log.push_back(cyc); end
            if (src_timeout)   begin check_pulse(3, "src_timeout");   tmo_log.push_back(cyc); end
        end
    end

    initial begin
        int f;
        logic [N-1:0] d;
        resetN = 1'b0; frame = 1'b0; src_enable = '0; src_done = '0; cur_en = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_start", int'(src_start), 0);
        chk("reset_sel", int'(write_source_sel), 0);
        chk("reset_flags", int'({write_awaited, pass_done, frame_overrun, src_timeout}), 0);
        idle(3);

        // Both sources enabled, each finishes normally.
        clear_logs(); cur_en = 2'b11;
        drive(1'b1, cur_en, '0); f = cyc;
        idle(9); drive(1'b0, cur_en, 2'b01);
        idle(9); drive(1'b0, cur_en, 2'b10);
        idle(4);
        chk("t1_nstart", start_log.size(), 2);
        chk("t1_start0", start_log[0], f + 2);
        chk("t1_start1", start_log[1], f + 12);
        chk("t1_sel1", start_id_log[1], 1);
        chk("t1_pass", pass_log[0], f + 22);

        // Only source 1 enabled.
        clear_logs(); cur_en = 2'b10;
        drive(1'b1, cur_en, '0); f = cyc;
        idle(4); drive(1'b0, cur_en, 2'b10);
        idle(4);
        chk("t2_start", start_log[0], f + 2);
        chk("t2_sel", start_id_log[0], 1);
        chk("t2_pass", pass_log[0], f + 7);

        // Nothing enabled; a second frame lands in the FINISH cycle.
        clear_logs(); cur_en = 2'b00;
        drive(1'b1, cur_en, '0); f = cyc;
        idle(1); drive(1'b1, cur_en, '0);
        idle(5);
        chk("t3_nstart", start_log.size(), 0);
        chk("t3_pass0", pass_log[0], f + 2);
        chk("t3_pass1", pass_log[1], f + 4);
        chk("t3_novr", ovr_log.size(), 0);

        // Source 0 hangs and is abandoned by the watchdog.
        clear_logs(); cur_en = 2'b11;
        drive(1'b1, cur_en, '0); f = cyc;
        idle(W + 5); drive(1'b0, cur_en, 2'b11);
        idle(4);
        chk("t4_tmo", tmo_log[0], f + 2 + W);
        chk("t4_start1", start_log[1], f + 4 + W);
        chk("t4_pass", pass_log[0], f + 8 + W);

        // Second frame during DRAW restarts the pass.
        clear_logs();
        drive(1'b1, cur_en, '0); f = cyc;
        idle(5); drive(1'b1, cur_en, '0);
        idle(2 * W + 10);
        chk("t5_ovr", ovr_log[0], f + 7);
        chk("t5_restart", start_log[1], f + 8);
        chk("t5_pass", pass_log[0], f + 12 + 2 * W);

        // Frame and done in the same DRAW cycle: frame wins.
        clear_logs();
        drive(1'b1, cur_en, '0); f = cyc;
        idle(4); drive(1'b1, cur_en, 2'b01);
        idle(2 * W + 10);
        chk("t6_ovr", ovr_log[0], f + 6);
        chk("t6_restart_id", start_id_log[1], 0);

        // Reset during DRAW.
        drive(1'b1, cur_en, '0);
        idle(4);
        do_reset();
        idle(8);
        chk("t7_no_start", start_log.size(), 0);
        chk("t7_no_pass", pass_log.size(), 0);

        // Randomised traffic: frequent dones first, then sparse ones so the watchdog fires.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(49) == 0) cur_en = N'($urandom);
            for (int b = 0; b < N; b++) d[b] = ($urandom_range((i < 2000) ? 5 : 25) == 0);
            drive($urandom_range(59) == 0, cur_en, d);
        end
        idle(3 * W + 10);
        @(negedge clk);
        #1;
        chk("end_events_drained", evq.size(), 0);
        chk("end_status_drained", stq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
